// File: rtl/cpu_data_responder.sv
// cpu_data_responder
// Target end of the CPU data bus. Each accepted request is decoded into
// on-chip RAM (single cycle, byte strobes), the peripheral window (forwarded
// over a request/ack port and aborted on timeout) or unmapped space (error).
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   cpu_request/address/write/wstrb/wdata   CPU request side
//   cpu_rdata, cpu_valid   read data and its one-cycle qualifier
//   cpu_mem_busy           high while a peripheral transaction is outstanding
//   periph_request/address/write/wstrb/wdata   registered peripheral request
//   periph_rdata, periph_ack                   peripheral completion
//   bus_error              one-cycle pulse on unmapped access or timeout
module cpu_data_responder #(
    parameter int unsigned RAM_WORDS   = 4096,
    parameter logic [7:0]  PERIPH_BASE = 8'hE0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_request,
    input  logic [31:0] cpu_address,
    input  logic        cpu_write,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_mem_busy,
    output logic        cpu_valid,
    output logic        periph_request,
    output logic [23:0] periph_address,
    output logic        periph_write,
    output logic [3:0]  periph_wstrb,
    output logic [31:0] periph_wdata,
    input  logic [31:0] periph_rdata,
    input  logic        periph_ack,
    output logic        bus_error
);

    localparam int unsigned RAM_AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES     = 33'(RAM_WORDS) * 33'd4;
    localparam logic [8:0]  TIMEOUT_LIMIT = 9'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PWAIT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         tmo_count_r;
    logic [7:0]         tmo_count_s;
    logic [8:0]         tmo_next_s;
    logic [31:0]        ram_mem [RAM_WORDS];
    logic [RAM_AW-1:0]  word_idx_s;
    logic [31:0]        ram_word_s;
    logic               accept_s;
    logic               is_ram_s;
    logic               is_periph_s;
    logic [3:0]         ram_wen_s;
    logic [31:0]        cpu_rdata_s;
    logic               cpu_valid_s;
    logic               cpu_busy_s;
    logic               preq_s;
    logic [23:0]        paddr_s;
    logic               pwrite_s;
    logic [3:0]         pwstrb_s;
    logic [31:0]        pwdata_s;
    logic               bus_error_s;

    // Acceptance and region decode of the request presented this cycle
    always_comb begin
        accept_s    = cpu_request & ~cpu_mem_busy;
        is_ram_s    = ({1'b0, cpu_address} < RAM_BYTES);
        is_periph_s = (cpu_address[31:24] == PERIPH_BASE);
        word_idx_s  = cpu_address[RAM_AW+1:2];
        ram_word_s  = ram_mem[word_idx_s];
    end

    // Next-state and next-output computation for the IDLE/PWAIT machine
    always_comb begin
        state_s     = state_r;
        tmo_count_s = tmo_count_r;
        // 9-bit so the limit compare cannot be fooled by an 8-bit wrap
        tmo_next_s  = {1'b0, tmo_count_r} + 9'd1;
        cpu_rdata_s = cpu_rdata;
        cpu_valid_s = 1'b0;
        cpu_busy_s  = cpu_mem_busy;
        preq_s      = periph_request;
        paddr_s     = periph_address;
        pwrite_s    = periph_write;
        pwstrb_s    = periph_wstrb;
        pwdata_s    = periph_wdata;
        bus_error_s = 1'b0;
        ram_wen_s   = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_ram_s) begin
                        if (cpu_write) begin
                            ram_wen_s = cpu_wstrb;
                        end else begin
                            cpu_rdata_s = ram_word_s;
                            cpu_valid_s = 1'b1;
                        end
                    end else if (is_periph_s) begin
                        preq_s      = 1'b1;
                        cpu_busy_s  = 1'b1;
                        paddr_s     = cpu_address[23:0];
                        pwrite_s    = cpu_write;
                        pwstrb_s    = cpu_wstrb;
                        pwdata_s    = cpu_wdata;
                        tmo_count_s = 8'd0;
                        state_s     = ST_PWAIT;
                    end else begin
                        // Unmapped: reads return zero, writes are dropped
                        bus_error_s = 1'b1;
                        if (cpu_write) begin
                            cpu_valid_s = 1'b0;
                        end else begin
                            cpu_rdata_s = 32'h0000_0000;
                            cpu_valid_s = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PWAIT: begin
                // Ack is tested first so it wins over a coincident timeout
                if (periph_ack) begin
                    preq_s     = 1'b0;
                    cpu_busy_s = 1'b0;
                    state_s    = ST_IDLE;
                    if (periph_write) begin
                        cpu_valid_s = 1'b0;
                    end else begin
                        cpu_rdata_s = periph_rdata;
                        cpu_valid_s = 1'b1;
                    end
                end else if (tmo_next_s >= TIMEOUT_LIMIT) begin
                    preq_s      = 1'b0;
                    cpu_busy_s  = 1'b0;
                    bus_error_s = 1'b1;
                    state_s     = ST_IDLE;
                    if (periph_write) begin
                        cpu_valid_s = 1'b0;
                    end else begin
                        cpu_rdata_s = 32'hDEAD_BEEF;
                        cpu_valid_s = 1'b1;
                    end
                end else begin
                    tmo_count_s = tmo_next_s[7:0];
                end
            end
            default: begin
                state_s    = ST_IDLE;
                preq_s     = 1'b0;
                cpu_busy_s = 1'b0;
            end
        endcase
    end

    // State, timeout counter and all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            tmo_count_r    <= 8'd0;
            cpu_rdata      <= 32'h0000_0000;
            cpu_valid      <= 1'b0;
            cpu_mem_busy   <= 1'b0;
            periph_request <= 1'b0;
            periph_address <= 24'h00_0000;
            periph_write   <= 1'b0;
            periph_wstrb   <= 4'b0000;
            periph_wdata   <= 32'h0000_0000;
            bus_error      <= 1'b0;
        end else begin
            state_r        <= state_s;
            tmo_count_r    <= tmo_count_s;
            cpu_rdata      <= cpu_rdata_s;
            cpu_valid      <= cpu_valid_s;
            cpu_mem_busy   <= cpu_busy_s;
            periph_request <= preq_s;
            periph_address <= paddr_s;
            periph_write   <= pwrite_s;
            periph_wstrb   <= pwstrb_s;
            periph_wdata   <= pwdata_s;
            bus_error      <= bus_error_s;
        end
    end

    // Byte-strobed RAM write; contents deliberately survive reset
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wen_s[b]) begin
                ram_mem[word_idx_s][8*b +: 8] <= cpu_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cpu_data_responder.sv
module tb_cpu_data_responder;

    localparam int unsigned RW = 4096;
    localparam int unsigned TO = 4;

    logic        clock;
    logic        reset;
    logic        cpu_request;
    logic [31:0] cpu_address;
    logic        cpu_write;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_mem_busy;
    logic        cpu_valid;
    logic        periph_request;
    logic [23:0] periph_address;
    logic        periph_write;
    logic [3:0]  periph_wstrb;
    logic [31:0] periph_wdata;
    logic [31:0] periph_rdata;
    logic        periph_ack;
    logic        bus_error;

    cpu_data_responder #(
        .RAM_WORDS  (RW),
        .PERIPH_BASE(8'hE0),
        .TIMEOUT    (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_request   (cpu_request),
        .cpu_address   (cpu_address),
        .cpu_write     (cpu_write),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_mem_busy  (cpu_mem_busy),
        .cpu_valid     (cpu_valid),
        .periph_request(periph_request),
        .periph_address(periph_address),
        .periph_write  (periph_write),
        .periph_wstrb  (periph_wstrb),
        .periph_wdata  (periph_wdata),
        .periph_rdata  (periph_rdata),
        .periph_ack    (periph_ack),
        .bus_error     (bus_error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    // Behavioural model state: expected outputs and a transaction record
    logic [31:0] mem_m [RW];
    logic [31:0] init_val [64];
    logic [31:0] exp_rdata  = '0;
    logic        exp_valid  = 1'b0;
    logic        exp_busy   = 1'b0;
    logic        exp_preq   = 1'b0;
    logic [23:0] exp_paddr  = '0;
    logic        exp_pwrite = 1'b0;
    logic [3:0]  exp_pwstrb = '0;
    logic [31:0] exp_pwdata = '0;
    logic        exp_berr   = 1'b0;
    logic        m_pend     = 1'b0;
    int unsigned m_elapsed  = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d);
        cpu_request = req;
        cpu_address = a;
        cpu_write   = w;
        cpu_wstrb   = s;
        cpu_wdata   = d;
    endtask

    // Transaction-level view of one clock edge
    task automatic model_step();
        int unsigned widx;
        if (!reset) begin
            exp_rdata = '0; exp_valid = 1'b0; exp_busy = 1'b0; exp_preq = 1'b0;
            exp_paddr = '0; exp_pwrite = 1'b0; exp_pwstrb = '0; exp_pwdata = '0;
            exp_berr = 1'b0; m_pend = 1'b0; m_elapsed = 0;
        end else begin
            exp_valid = 1'b0;
            exp_berr  = 1'b0;
            if (m_pend) begin
                m_elapsed++;
                if (periph_ack || m_elapsed == TO) begin
                    m_pend   = 1'b0;
                    exp_busy = 1'b0;
                    exp_preq = 1'b0;
                    exp_berr = !periph_ack;
                    if (!exp_pwrite) begin
                        exp_rdata = periph_ack ? periph_rdata : 32'hDEADBEEF;
                        exp_valid = 1'b1;
                    end
                end
            end else if (cpu_request) begin
                if (cpu_address < 32'(RW * 4)) begin
                    widx = cpu_address / 4;
                    if (cpu_write) begin
                        for (int b = 0; b < 4; b++)
                            if (cpu_wstrb[b]) mem_m[widx][8*b +: 8] = cpu_wdata[8*b +: 8];
                    end else begin
                        exp_rdata = mem_m[widx];
                        exp_valid = 1'b1;
                    end
                end else if (cpu_address[31:24] == 8'hE0) begin
                    m_pend     = 1'b1;
                    m_elapsed  = 0;
                    exp_busy   = 1'b1;
                    exp_preq   = 1'b1;
                    exp_paddr  = cpu_address[23:0];
                    exp_pwrite = cpu_write;
                    exp_pwstrb = cpu_wstrb;
                    exp_pwdata = cpu_wdata;
                end else begin
                    exp_berr = 1'b1;
                    if (!cpu_write) begin
                        exp_rdata = 32'h0;
                        exp_valid = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            model_step();
        end
    end

    // Compare process: every output against the model on each falling edge
    initial begin
        forever begin
            @(negedge clock);
            if (check_en) begin
                chk("cpu_valid",      32'(cpu_valid),      32'(exp_valid));
                chk("cpu_rdata",      cpu_rdata,           exp_rdata);
                chk("cpu_mem_busy",   32'(cpu_mem_busy),   32'(exp_busy));
                chk("periph_request", 32'(periph_request), 32'(exp_preq));
                chk("periph_address", 32'(periph_address), 32'(exp_paddr));
                chk("periph_write",   32'(periph_write),   32'(exp_pwrite));
                chk("periph_wstrb",   32'(periph_wstrb),   32'(exp_pwstrb));
                chk("periph_wdata",   periph_wdata,        exp_pwdata);
                chk("bus_error",      32'(bus_error),      32'(exp_berr));
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: return 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            4:          return 32'((RW - 1) * 4);
            5:          return 32'(RW * 4) + 32'($urandom_range(0, 255));
            6, 7:       return {8'hE0, 24'($urandom)};
            8:          return {8'hE1, 24'($urandom)};
            default:    return 32'h4000_0000 | 32'($urandom);
        endcase
    endfunction

    initial begin
        int n_hi;
        logic seen;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        periph_ack   = 1'b0;
        periph_rdata = 32'h0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_en = 1'b1;
        chk("rst_valid", 32'(cpu_valid), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_busy",  32'(cpu_mem_busy), 32'd0);
        chk("rst_preq",  32'(periph_request), 32'd0);
        chk("rst_berr",  32'(bus_error), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Fill the RAM words the rest of the run touches
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            init_val[i] = $urandom;
            drive(1'b1, 32'(i * 4), 1'b1, 4'hF, init_val[i]);
        end
        @(negedge clock);
        drive(1'b1, 32'((RW - 1) * 4), 1'b1, 4'hF, 32'h5A5A_0FF0);

        // RAM write, partial write, read back
        @(negedge clock); drive(1'b1, 32'h100, 1'b1, 4'hF, 32'h1234_5678);
        @(negedge clock); drive(1'b1, 32'h100, 1'b1, 4'h2, 32'h0000_AB00);
        @(negedge clock); drive(1'b1, 32'h100, 1'b0, 4'h0, 32'h0);
        @(negedge clock); drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("rmw_valid", 32'(cpu_valid), 32'd1);
        chk("rmw_rdata", cpu_rdata, 32'h1234_AB78);
        chk("rmw_busy",  32'(cpu_mem_busy), 32'd0);

        // Back-to-back RAM reads
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i > 0) begin
                chk("b2b_valid", 32'(cpu_valid), 32'd1);
                chk("b2b_rdata", cpu_rdata, init_val[i-1]);
                chk("b2b_busy",  32'(cpu_mem_busy), 32'd0);
            end
            if (i < 3) drive(1'b1, 32'(i * 4), 1'b0, 4'h0, 32'h0);
            else       drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        end

        // Peripheral read, ack in the 4th waiting cycle (coincides with timeout)
        @(negedge clock); drive(1'b1, 32'hE000_0010, 1'b0, 4'h0, 32'h0);
        @(negedge clock); drive(1'b1, 32'h4, 1'b0, 4'h0, 32'h0);
        chk("prd_req",  32'(periph_request), 32'd1);
        chk("prd_addr", 32'(periph_address), 32'h10);
        chk("prd_busy", 32'(cpu_mem_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("prd_wait_busy",  32'(cpu_mem_busy), 32'd1);
            chk("prd_wait_valid", 32'(cpu_valid), 32'd0);
            if (i == 2) begin
                periph_ack   = 1'b1;
                periph_rdata = 32'hCAFE_F00D;
            end
        end
        @(negedge clock);
        periph_ack = 1'b0;
        chk("prd_valid", 32'(cpu_valid), 32'd1);
        chk("prd_rdata", cpu_rdata, 32'hCAFE_F00D);
        chk("prd_busy_drop", 32'(cpu_mem_busy), 32'd0);
        chk("prd_no_berr", 32'(bus_error), 32'd0);
        @(negedge clock); drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("held_valid", 32'(cpu_valid), 32'd1);
        chk("held_rdata", cpu_rdata, init_val[1]);

        // Peripheral timeout
        @(negedge clock); drive(1'b1, 32'hE000_0020, 1'b0, 4'h0, 32'h0);
        n_hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            if (periph_request) n_hi++;
            if (cpu_valid) begin
                seen = 1'b1;
                chk("tmo_berr",  32'(bus_error), 32'd1);
                chk("tmo_rdata", cpu_rdata, 32'hDEAD_BEEF);
            end
        end
        chk("tmo_req_cycles", 32'(n_hi), 32'd4);
        chk("tmo_seen", {31'd0, seen}, 32'd1);

        // Unmapped read and write
        @(negedge clock); drive(1'b1, 32'h4000_0000, 1'b0, 4'h0, 32'h0);
        @(negedge clock); drive(1'b1, 32'h4000_0000, 1'b1, 4'hF, 32'hFFFF_FFFF);
        chk("unm_rd_valid", 32'(cpu_valid), 32'd1);
        chk("unm_rd_rdata", cpu_rdata, 32'h0);
        chk("unm_rd_berr",  32'(bus_error), 32'd1);
        @(negedge clock); drive(1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("unm_wr_berr",  32'(bus_error), 32'd1);
        chk("unm_wr_valid", 32'(cpu_valid), 32'd0);
        @(negedge clock); drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("unm_ram_kept", cpu_rdata, init_val[0]);

        // Reset while a peripheral transaction is outstanding
        @(negedge clock); drive(1'b1, 32'hE000_0030, 1'b0, 4'h0, 32'h0);
        @(negedge clock); drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("mid_req", 32'(periph_request), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req",   32'(periph_request), 32'd0);
        chk("mid_rst_busy",  32'(cpu_mem_busy), 32'd0);
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_addr",  32'(periph_address), 32'h0);
        @(negedge clock);
        @(negedge clock); reset = 1'b1; periph_ack = 1'b1;
        @(negedge clock); periph_ack = 1'b0;
        chk("post_rst_valid", 32'(cpu_valid), 32'd0);
        chk("post_rst_busy",  32'(cpu_mem_busy), 32'd0);
        @(negedge clock); drive(1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
        chk("post_rst_valid2", 32'(cpu_valid), 32'd0);
        @(negedge clock); drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("post_rst_idle_rd", cpu_rdata, init_val[2]);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            drive($urandom_range(0, 9) < 6, rand_addr(), 1'($urandom_range(0, 1)),
                  4'($urandom), 32'($urandom));
            periph_ack   = ($urandom_range(0, 99) < 30);
            periph_rdata = 32'($urandom);
        end
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        periph_ack = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
